// File: rtl/vga_fml_fetch_if.sv
// vga_fml_fetch_if: lcd request side (csr_*) and FML read port (fml_*).
// master = fetch stage, slave = lcd/FML environment.
interface vga_fml_fetch_if #(
  parameter int fml_depth = 25
);
  logic [17:1]          csr_adr_i;
  logic                 csr_stb_i;
  logic [15:0]          csr_dat_o;
  logic                 csr_ack_o;
  logic [fml_depth-1:0] fml_adr_o;
  logic                 fml_stb_o;
  logic                 fml_ack_i;
  logic [15:0]          fml_di;

  modport master (
    input  csr_adr_i, csr_stb_i,
    output csr_dat_o, csr_ack_o,
    output fml_adr_o, fml_stb_o,
    input  fml_ack_i, fml_di
  );

  modport slave (
    output csr_adr_i, csr_stb_i,
    input  csr_dat_o, csr_ack_o,
    input  fml_adr_o, fml_stb_o,
    output fml_ack_i, fml_di
  );
endinterface

// File: rtl/vga_fml_fetch.sv
// vga_fml_fetch: lcd word requests -> held FML reads, 2-deep address queue,
// ports: wb_clk_i, wb_rst_n_i, clk_en_i, bus (master), ready_o, ovf_o.
module vga_fml_fetch #(
  parameter int                   fml_depth     = 25,
  parameter logic [fml_depth-1:0] FB_BASE       = fml_depth'(25'h00B8000),
  parameter logic [23:0]          STARTUP_TICKS = 24'hFFFFFF
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic            clk_en_i,
  vga_fml_fetch_if.master bus,
  output logic            ready_o,
  output logic            ovf_o
);

  typedef enum logic [1:0] {
    DISABLED,
    IDLE,
    REQ
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [23:0]          tick_q;
  logic [fml_depth-1:0] fifo_q [2];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           cnt_q;
  logic [fml_depth-1:0] push_adr;
  logic                 ready_set;
  logic                 push_req;
  logic                 push;
  logic                 pop;
  logic                 load;
  logic                 dis_ack;

  // byte address, wraps modulo 2^fml_depth
  assign push_adr = FB_BASE + fml_depth'({bus.csr_adr_i, 1'b0});

  assign ready_set = !ready_o && clk_en_i
                   && (tick_q == STARTUP_TICKS - 24'd1);
  assign push_req  = bus.csr_stb_i && ready_o;
  assign pop       = (state_q == REQ) && bus.fml_ack_i;
  // a full queue still accepts when the head retires this cycle
  assign push      = push_req && ((cnt_q != 2'd2) || pop);
  assign dis_ack   = bus.csr_stb_i && !ready_o;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= DISABLED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      DISABLED: begin
        if (ready_set) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (cnt_q != 2'd0) begin
          state_d = REQ;
          load    = 1'b1;
        end
      end
      REQ: begin
        if (bus.fml_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = DISABLED;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      tick_q  <= '0;
      ready_o <= 1'b0;
    end else if (!ready_o && clk_en_i) begin
      tick_q <= tick_q + 24'd1;
      if (ready_set) begin
        ready_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      ovf_o     <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_adr;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      if (push_req && !push) begin
        ovf_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      bus.fml_stb_o <= 1'b0;
      bus.fml_adr_o <= FB_BASE;
      bus.csr_dat_o <= 16'h0000;
      bus.csr_ack_o <= 1'b0;
    end else begin
      if (load) begin
        bus.fml_stb_o <= 1'b1;
        bus.fml_adr_o <= fifo_q[rd_ptr_q];
      end else if (pop) begin
        bus.fml_stb_o <= 1'b0;
      end
      bus.csr_ack_o <= pop || dis_ack;
      if (pop) begin
        bus.csr_dat_o <= bus.fml_di;
      end else if (dis_ack) begin
        bus.csr_dat_o <= 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_vga_fml_fetch.sv
// tb_vga_fml_fetch: scoreboard bench for vga_fml_fetch, plus a
// narrow-address instance for the wrap case.
module tb_vga_fml_fetch;

  typedef struct {
    logic [15:0] dat;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;
  logic ready;
  logic ovf;
  logic rst2_n;
  logic clk_en2;
  logic ready2;
  logic ovf2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ack_cyc = -1000;
  int rise_cyc = 0;
  int fml_lat = 5;
  int hi_cnt = 0;
  bit fml_auto = 1'b1;
  bit prev_stb = 1'b0;
  logic [24:0] held_exp = '0;
  exp_t me;

  exp_t        exp_q[$];
  logic [24:0] adr_q[$];
  logic [15:0] rsp_q[$];

  vga_fml_fetch_if #(.fml_depth(25)) bus ();
  vga_fml_fetch_if #(.fml_depth(17)) bus2 ();

  vga_fml_fetch #(
    .fml_depth    (25),
    .FB_BASE      (25'h00B8000),
    .STARTUP_TICKS(24'd4)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .clk_en_i  (clk_en),
    .bus       (bus.master),
    .ready_o   (ready),
    .ovf_o     (ovf)
  );

  vga_fml_fetch #(
    .fml_depth    (17),
    .FB_BASE      (17'h1FFFE),
    .STARTUP_TICKS(24'd1)
  ) dut2 (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst2_n),
    .clk_en_i  (clk_en2),
    .bus       (bus2.master),
    .ready_o   (ready2),
    .ovf_o     (ovf2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FML slave model: acks after fml_lat strobe-high cycles
  initial begin
    forever begin
      tick();
      if (fml_auto) begin
        bus.fml_ack_i = 1'b0;
        if (bus.fml_stb_o) begin
          hi_cnt++;
          if (hi_cnt == fml_lat) begin
            bus.fml_ack_i = 1'b1;
            bus.fml_di = (rsp_q.size() != 0) ? rsp_q.pop_front() : 16'hDEAD;
            last_ack_cyc = cyc;
            hi_cnt = 0;
          end
        end else begin
          hi_cnt = 0;
        end
      end
    end
  end

  // response monitor
  always @(negedge clk) begin
    if (rst_n && bus.csr_ack_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {16'h0, bus.csr_dat_o}, 32'hFFFF_FFFF);
      end else begin
        me = exp_q.pop_front();
        check("ack_data", {16'h0, bus.csr_dat_o}, {16'h0, me.dat});
        if (me.cyc >= 0) check("ack_cycle_dis", cyc, me.cyc);
        else check("ack_cycle_fml", cyc, last_ack_cyc + 1);
      end
    end
  end

  // strobe monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stb <= 1'b0;
    end else begin
      if (bus.fml_stb_o && !prev_stb) begin
        rise_cyc <= cyc;
        if (adr_q.size() == 0) begin
          check("unexpected_stb", {7'h0, bus.fml_adr_o}, 32'hFFFF_FFFF);
        end else begin
          held_exp <= adr_q[0];
          check("fml_adr", {7'h0, bus.fml_adr_o}, {7'h0, adr_q.pop_front()});
        end
        check("stb_gap", {31'h0, cyc >= last_ack_cyc + 2}, 32'd1);
      end
      if (bus.fml_stb_o && prev_stb)
        check("adr_stable", {7'h0, bus.fml_adr_o}, {7'h0, held_exp});
      if (!bus.fml_stb_o && prev_stb && fml_auto)
        check("stb_width", cyc - rise_cyc, fml_lat);
      prev_stb <= bus.fml_stb_o;
    end
  end

  task automatic drain(input int n);
    int k = 0;
    while ((exp_q.size() != 0 || adr_q.size() != 0 || bus.fml_stb_o)
           && k < n) begin
      tick();
      k++;
    end
    if (k >= n) check("drain_timeout", exp_q.size() + adr_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic req(input logic [16:0] a, input logic [24:0] ea,
                     input logic [15:0] d);
    bus.csr_adr_i = a;
    bus.csr_stb_i = 1'b1;
    adr_q.push_back(ea);
    exp_q.push_back('{dat: d, cyc: -1});
    rsp_q.push_back(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int m;
    int k;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    clk_en = 1'b0;
    clk_en2 = 1'b0;
    bus.csr_adr_i = '0;
    bus.csr_stb_i = 1'b0;
    bus.fml_ack_i = 1'b0;
    bus.fml_di = '0;
    bus2.csr_adr_i = '0;
    bus2.csr_stb_i = 1'b0;
    bus2.fml_ack_i = 1'b0;
    bus2.fml_di = '0;
    tick();
    tick();
    @(negedge clk);
    check("rst_stb", {31'h0, bus.fml_stb_o}, 0);
    check("rst_adr", {7'h0, bus.fml_adr_o}, 32'h00B8000);
    check("rst_dat", {16'h0, bus.csr_dat_o}, 0);
    check("rst_ack", {31'h0, bus.csr_ack_o}, 0);
    check("rst_ready", {31'h0, ready}, 0);
    check("rst_ovf", {31'h0, ovf}, 0);

    // narrow instance: single-pulse startup and address wrap
    tick();
    rst2_n = 1'b1;
    rst_n = 1'b1;
    clk_en2 = 1'b1;
    @(negedge clk);
    check("w_ready_before", {31'h0, ready2}, 0);
    tick();
    @(negedge clk);
    check("w_ready_after", {31'h0, ready2}, 1);
    tick();
    bus2.csr_adr_i = 17'h00001;
    bus2.csr_stb_i = 1'b1;
    tick();
    bus2.csr_stb_i = 1'b0;
    k = 0;
    while (!bus2.fml_stb_o && k < 10) begin
      tick();
      k++;
    end
    check("w_stb_seen", {31'h0, bus2.fml_stb_o}, 1);
    check("w_adr_wrap", {15'h0, bus2.fml_adr_o}, 32'h0);
    bus2.fml_ack_i = 1'b1;
    bus2.fml_di = 16'h1234;
    tick();
    bus2.fml_ack_i = 1'b0;
    @(negedge clk);
    check("w_ack", {31'h0, bus2.csr_ack_o}, 1);
    check("w_dat", {16'h0, bus2.csr_dat_o}, 32'h1234);

    // startup: 4 pulses, disabled-path requests on pulses 2 and 4
    for (int p = 1; p <= 4; p++) begin
      tick();
      tick();
      tick();
      tick();
      clk_en = 1'b1;
      if (p == 2 || p == 4) begin
        bus.csr_adr_i = 17'h00055;
        bus.csr_stb_i = 1'b1;
        exp_q.push_back('{dat: 16'h0000, cyc: cyc + 1});
      end
      tick();
      clk_en = 1'b0;
      bus.csr_stb_i = 1'b0;
      @(negedge clk);
      check("ready_pulse", {31'h0, ready}, {31'h0, p == 4});
    end
    drain(20);

    // single read
    fml_lat = 5;
    tick();
    req(17'h00010, 25'h00B8020, 16'hA55A);
    tick();
    bus.csr_stb_i = 1'b0;
    drain(50);

    // push and pop in the ack cycle
    tick();
    m = cyc;
    req(17'h00020, 25'h00B8040, 16'h1111);
    tick();
    bus.csr_stb_i = 1'b0;
    while (cyc < m + 6) tick();
    m = cyc;
    req(17'h00021, 25'h00B8042, 16'h2222);
    tick();
    bus.csr_stb_i = 1'b0;
    drain(50);
    check("pp_next_stb", rise_cyc, m + 2);
    check("pp_no_ovf", {31'h0, ovf}, 0);

    // overflow: three back-to-back requests, third dropped
    fml_lat = 10;
    tick();
    req(17'h00100, 25'h00B8200, 16'h3333);
    tick();
    req(17'h00101, 25'h00B8202, 16'h4444);
    tick();
    bus.csr_adr_i = 17'h00102;
    @(negedge clk);
    check("ovf_before", {31'h0, ovf}, 0);
    tick();
    bus.csr_stb_i = 1'b0;
    @(negedge clk);
    check("ovf_set", {31'h0, ovf}, 1);
    drain(80);

    // asynchronous reset mid-transaction, then a stale ack
    fml_auto = 1'b0;
    bus.fml_ack_i = 1'b0;
    tick();
    req(17'h00030, 25'h00B8060, 16'hFFFF);
    exp_q.delete();
    rsp_q.delete();
    tick();
    bus.csr_stb_i = 1'b0;
    k = 0;
    while (!bus.fml_stb_o && k < 10) begin
      tick();
      k++;
    end
    check("mr_stb_up", {31'h0, bus.fml_stb_o}, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_stb_async", {31'h0, bus.fml_stb_o}, 0);
    check("mr_ovf_async", {31'h0, ovf}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    bus.fml_ack_i = 1'b1;
    bus.fml_di = 16'hBEEF;
    @(negedge clk);
    check("mr_no_ack0", {31'h0, bus.csr_ack_o}, 0);
    tick();
    bus.fml_ack_i = 1'b0;
    @(negedge clk);
    check("mr_no_ack1", {31'h0, bus.csr_ack_o}, 0);
    check("mr_dat", {16'h0, bus.csr_dat_o}, 0);
    check("mr_ready", {31'h0, ready}, 0);
    check("mr_stb_low", {31'h0, bus.fml_stb_o}, 0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
